// File: rtl/gamma_lut_prog_pkg.sv
// Shared definitions for the programmable gamma LUT block.
// Holds the default colour width / tag width / channel count, the control
// FSM state encoding, and a helper that sizes the channel field of a table index.
package gamma_lut_prog_pkg;

  localparam int GAMMA_COLOR_DEPTH   = 8;  // pixel and table-entry width
  localparam int GAMMA_COLOR_BIT_CNT = 2;  // colour tag width
  localparam int GAMMA_NUM_CH        = 3;  // number of gamma tables

  typedef enum logic {
    ST_INIT = 1'b0,  // identity fill of every table, one entry per cycle
    ST_RUN  = 1'b1   // tables programmable, lookups live
  } gamma_state_e;

  // Bits needed to select one of num_ch tables (at least one bit).
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/gamma_lut_prog_if.sv
// Pixel stream + table configuration bus of the gamma LUT block.
// Ports: pixel_in/valid_in/color_in/last_pic_in/bypass_en in, pixel_out/valid_out/
// color_out/last_pic_out out; cfg_valid/cfg_ready/cfg_ch/cfg_addr/cfg_data write
// channel; init_busy status. With GAMMA_RDBACK_EN: cfg_re/cfg_rdata/cfg_rvalid.
interface gamma_lut_prog_if
  import gamma_lut_prog_pkg::*;
#(
  parameter int COLOR_DEPTH   = GAMMA_COLOR_DEPTH,
  parameter int COLOR_BIT_CNT = GAMMA_COLOR_BIT_CNT
);

  // pixel stream in
  logic [COLOR_DEPTH-1:0]   pixel_in;
  logic                     valid_in;
  logic [COLOR_BIT_CNT-1:0] color_in;
  logic                     last_pic_in;
  logic                     bypass_en;

  // table write channel
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [COLOR_BIT_CNT-1:0] cfg_ch;
  logic [COLOR_DEPTH-1:0]   cfg_addr;
  logic [COLOR_DEPTH-1:0]   cfg_data;
`ifdef GAMMA_RDBACK_EN
  // table readback channel
  logic                     cfg_re;
  logic [COLOR_DEPTH-1:0]   cfg_rdata;
  logic                     cfg_rvalid;
`endif

  // status and pixel stream out
  logic                     init_busy;
  logic [COLOR_DEPTH-1:0]   pixel_out;
  logic                     valid_out;
  logic [COLOR_BIT_CNT-1:0] color_out;
  logic                     last_pic_out;

  // Upstream / host side.
  modport master (
    output pixel_in, valid_in, color_in, last_pic_in, bypass_en,
    output cfg_valid, cfg_ch, cfg_addr, cfg_data,
`ifdef GAMMA_RDBACK_EN
    output cfg_re,
    input  cfg_rdata, cfg_rvalid,
`endif
    input  cfg_ready, init_busy, pixel_out, valid_out, color_out, last_pic_out
  );

  // The LUT block itself.
  modport slave (
    input  pixel_in, valid_in, color_in, last_pic_in, bypass_en,
    input  cfg_valid, cfg_ch, cfg_addr, cfg_data,
`ifdef GAMMA_RDBACK_EN
    input  cfg_re,
    output cfg_rdata, cfg_rvalid,
`endif
    output cfg_ready, init_busy, pixel_out, valid_out, color_out, last_pic_out
  );

endinterface

// File: rtl/gamma_lut_bank.sv
// Table storage for all gamma channels, flattened into one array indexed {ch, code}.
// Ports: clk/rst_n; one synchronous write port (wr_*); one registered pixel read
// port (rd_*); readback port (rb_*) present only with GAMMA_RDBACK_EN.
module gamma_lut_bank
  import gamma_lut_prog_pkg::*;
#(
  parameter int DW    = GAMMA_COLOR_DEPTH,
  parameter int AW    = 10,
  parameter int DEPTH = 768
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
`ifdef GAMMA_RDBACK_EN
  input  logic          rb_en,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
`endif
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  // Contents are not reset; the owner refills them after every reset.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Reads sample the array before this edge's write lands, so a same-cycle
  // write to the entry being read returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

`ifdef GAMMA_RDBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data <= '0;
    end else if (rb_en) begin
      rb_data <= mem[rb_addr];
    end
  end
`endif

endmodule

// File: rtl/gamma_lut_prog.sv
// Programmable per-colour gamma LUT: 2-cycle pixel pipeline (input reg, registered lookup).
// Ports: clk, rst_n (async, active-low), bus (gamma_lut_prog_if.slave: pixel stream,
// table write channel, init_busy). Optional readback channel under GAMMA_RDBACK_EN.
module gamma_lut_prog
  import gamma_lut_prog_pkg::*;
#(
  parameter int COLOR_DEPTH   = GAMMA_COLOR_DEPTH,
  parameter int COLOR_BIT_CNT = GAMMA_COLOR_BIT_CNT,
  parameter int NUM_CH        = GAMMA_NUM_CH
)(
  input  logic            clk,
  input  logic            rst_n,
  gamma_lut_prog_if.slave bus
);

  localparam int CH_W  = ch_idx_w(NUM_CH);
  localparam int AW    = CH_W + COLOR_DEPTH;
  localparam int DEPTH = NUM_CH << COLOR_DEPTH;  // NUM_CH tables of 2^COLOR_DEPTH entries

  localparam logic [AW-1:0]            LAST_IDX   = AW'(DEPTH - 1);
  // One extra bit so NUM_CH == 2^COLOR_BIT_CNT still compares correctly.
  localparam logic [COLOR_BIT_CNT:0]   NUM_CH_TAG = (COLOR_BIT_CNT + 1)'(NUM_CH);

  // Tag selects an existing table.
  function automatic logic tag_ok(input logic [COLOR_BIT_CNT-1:0] tag);
    return ({1'b0, tag} < NUM_CH_TAG);
  endfunction

  // Flat table index; out-of-range tags map to entry 0 so the array is never
  // addressed past its end (the result is discarded by the caller).
  function automatic logic [AW-1:0] lut_idx(input logic [COLOR_BIT_CNT-1:0] tag,
                                            input logic [COLOR_DEPTH-1:0]   code);
    return tag_ok(tag) ? {tag[CH_W-1:0], code} : '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM: INIT walks every entry writing identity, then RUN forever.
  // ---------------------------------------------------------------------------
  gamma_state_e            state_q, state_d;
  logic [AW-1:0]           init_cnt_q, init_cnt_d;
  logic                    lut_we;
  logic [AW-1:0]           lut_waddr;
  logic [COLOR_DEPTH-1:0]  lut_wdata;
  logic                    init_busy_c;
  logic                    cfg_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    lut_we      = 1'b0;
    lut_waddr   = '0;
    lut_wdata   = '0;
    init_busy_c = 1'b0;
    cfg_ready_c = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_busy_c = 1'b1;
        lut_we      = 1'b1;
        lut_waddr   = init_cnt_q;
        // Low bits of the flat index are the input code, which is the identity value.
        lut_wdata   = init_cnt_q[COLOR_DEPTH-1:0];
        if (init_cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        cfg_ready_c = 1'b1;
        // Writes to a non-existent table are accepted but dropped.
        if (bus.cfg_valid && cfg_ready_c && tag_ok(bus.cfg_ch)) begin
          lut_we    = 1'b1;
          lut_waddr = lut_idx(bus.cfg_ch, bus.cfg_addr);
          lut_wdata = bus.cfg_data;
        end
      end
    endcase
  end

  assign bus.init_busy = init_busy_c;
  assign bus.cfg_ready = cfg_ready_c;

  // ---------------------------------------------------------------------------
  // Pixel pipeline: stage 1 = input register, stage 2 = registered lookup.
  // Free-running; valid only travels alongside the data.
  // ---------------------------------------------------------------------------
  logic [COLOR_DEPTH-1:0]   s1_pixel, s2_pixel;
  logic [COLOR_BIT_CNT-1:0] s1_color, s2_color;
  logic                     s1_valid, s2_valid;
  logic                     s1_last,  s2_last;
  logic                     s2_pass;
  logic [COLOR_DEPTH-1:0]   lut_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pixel <= '0;
      s1_color <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_pixel <= '0;
      s2_color <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_pass  <= 1'b0;
    end else begin
      s1_pixel <= bus.pixel_in;
      s1_color <= bus.color_in;
      s1_valid <= bus.valid_in;
      s1_last  <= bus.last_pic_in;
      s2_pixel <= s1_pixel;
      s2_color <= s1_color;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      // Tables are half-filled during INIT, so pixels pass through until RUN.
      s2_pass  <= bus.bypass_en | (state_q == ST_INIT) | ~tag_ok(s1_color);
    end
  end

  // Both mux inputs are registers, and both are 0 in reset, so pixel_out is too.
  assign bus.pixel_out    = s2_pass ? s2_pixel : lut_rdata;
  assign bus.valid_out    = s2_valid;
  assign bus.color_out    = s2_color;
  assign bus.last_pic_out = s2_last;

  // ---------------------------------------------------------------------------
  // Optional readback of table contents.
  // ---------------------------------------------------------------------------
`ifdef GAMMA_RDBACK_EN
  logic                   rb_en;
  logic                   rb_vld_q;
  logic                   rb_ok_q;
  logic [COLOR_DEPTH-1:0] rb_data;

  assign rb_en = bus.cfg_re && (state_q == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_vld_q <= 1'b0;
      rb_ok_q  <= 1'b0;
    end else begin
      rb_vld_q <= rb_en;
      if (rb_en) begin
        rb_ok_q <= tag_ok(bus.cfg_ch);
      end
    end
  end

  assign bus.cfg_rvalid = rb_vld_q;
  assign bus.cfg_rdata  = rb_ok_q ? rb_data : '0;
`endif

  gamma_lut_bank #(
    .DW    (COLOR_DEPTH),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (lut_we),
    .wr_addr (lut_waddr),
    .wr_data (lut_wdata),
`ifdef GAMMA_RDBACK_EN
    .rb_en   (rb_en),
    .rb_addr (lut_idx(bus.cfg_ch, bus.cfg_addr)),
    .rb_data (rb_data),
`endif
    .rd_addr (lut_idx(s1_color, s1_pixel)),
    .rd_data (lut_rdata)
  );

endmodule

// File: tb/tb_gamma_lut_prog.sv
// Self-checking bench for gamma_lut_prog: directed steps plus a randomised phase,
// all outputs compared every cycle against a table/queue-level reference model.
// Readback checks are compiled in when GAMMA_RDBACK_EN is defined.
module tb_gamma_lut_prog;
  import gamma_lut_prog_pkg::*;

  localparam int CD   = 8;
  localparam int CB   = 2;
  localparam int NCH  = 3;
  localparam int NENT = NCH * (1 << CD);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gamma_lut_prog_if #(.COLOR_DEPTH(CD), .COLOR_BIT_CNT(CB)) bus ();

  gamma_lut_prog #(.COLOR_DEPTH(CD), .COLOR_BIT_CNT(CB), .NUM_CH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: the gamma tables, cycles of INIT left, and the sample
  // that is one cycle into the pipe.
  int tbl [NCH][1 << CD];
  int init_left;
  int m_pix, m_col, m_vld, m_last;
  int e_pix, e_col, e_vld, e_last, e_rvalid, e_rdata;
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the model by one cycle, then compare every output.
  task automatic tick();
    @(posedge clk);
    if (bus.bypass_en || init_left > 0 || m_col >= NCH) e_pix = m_pix;
    else e_pix = tbl[m_col][m_pix];
    e_col  = m_col;
    e_vld  = m_vld;
    e_last = m_last;
    e_rvalid = 0;
`ifdef GAMMA_RDBACK_EN
    if (init_left == 0 && bus.cfg_re) begin
      e_rvalid = 1;
      if (int'(bus.cfg_ch) < NCH) e_rdata = tbl[bus.cfg_ch][bus.cfg_addr];
      else e_rdata = 0;
    end
`endif
    if (init_left > 0) init_left--;
    else if (bus.cfg_valid && int'(bus.cfg_ch) < NCH)
      tbl[bus.cfg_ch][bus.cfg_addr] = int'(bus.cfg_data);
    m_pix  = int'(bus.pixel_in);
    m_col  = int'(bus.color_in);
    m_vld  = int'(bus.valid_in);
    m_last = int'(bus.last_pic_in);
    #1;
    chk("pixel_out",    32'(bus.pixel_out),    e_pix);
    chk("valid_out",    32'(bus.valid_out),    e_vld);
    chk("color_out",    32'(bus.color_out),    e_col);
    chk("last_pic_out", 32'(bus.last_pic_out), e_last);
    chk("init_busy",    32'(bus.init_busy),    (init_left > 0) ? 1 : 0);
    chk("cfg_ready",    32'(bus.cfg_ready),    (init_left > 0) ? 0 : 1);
`ifdef GAMMA_RDBACK_EN
    chk("cfg_rvalid",   32'(bus.cfg_rvalid),   e_rvalid);
    if (e_rvalid != 0) chk("cfg_rdata", 32'(bus.cfg_rdata), e_rdata);
`endif
  endtask

  // Assert reset mid-cycle, check the reset values, release on a falling edge.
  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_pixel_out", 32'(bus.pixel_out),    0);
    chk("rst_valid_out", 32'(bus.valid_out),    0);
    chk("rst_color_out", 32'(bus.color_out),    0);
    chk("rst_last_out",  32'(bus.last_pic_out), 0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready),    0);
    chk("rst_init_busy", 32'(bus.init_busy),    1);
`ifdef GAMMA_RDBACK_EN
    chk("rst_cfg_rvalid", 32'(bus.cfg_rvalid),  0);
`endif
    repeat (hold) @(negedge clk);
    init_left = NENT;
    m_pix = 0; m_col = 0; m_vld = 0; m_last = 0;
    // Programmed values are lost; after INIT every table is the identity.
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < (1 << CD); a++) tbl[c][a] = a;
    rst_n = 1'b1;
  endtask

  task automatic drive_pix(input int pix, input int col, input bit vld, input bit last);
    bus.pixel_in    = 8'(pix);
    bus.color_in    = 2'(col);
    bus.valid_in    = vld;
    bus.last_pic_in = last;
  endtask

  task automatic drive_cfg(input bit vld, input int ch, input int addr, input int data);
    bus.cfg_valid = vld;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_addr  = 8'(addr);
    bus.cfg_data  = 8'(data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_pix(100, 1, 1'b1, 1'b0);
    drive_cfg(1'b0, 0, 0, 0);
    bus.bypass_en = 1'b0;
`ifdef GAMMA_RDBACK_EN
    bus.cfg_re = 1'b0;
`endif

    // Reset, then reset again part-way through INIT with ignored writes pending.
    do_reset(3);
    for (int i = 0; i < 100; i++) begin
      drive_cfg(1'($urandom_range(0, 1)), 1, 100, int'($urandom_range(0, 255)));
      tick();
    end
    drive_cfg(1'b0, 0, 0, 0);
    do_reset(2);

    // Full INIT with pixel 100 / colour 1; valid toggles to expose the 2-cycle delay.
    n = 0;
`ifdef GAMMA_RDBACK_EN
    bus.cfg_re = 1'b1;  // ignored while INIT runs
`endif
    do begin
      bus.valid_in    = 1'($urandom_range(0, 1));
      bus.last_pic_in = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (n >= 2) chk("init_pix100", 32'(bus.pixel_out), 100);
    end while (bus.init_busy && n < 2000);
    chk("init_len", n, NENT);
`ifdef GAMMA_RDBACK_EN
    bus.cfg_re = 1'b0;
`endif
    tick();
    tick();
    chk("run_pix100", 32'(bus.pixel_out), 100);

    // Program ch1[100]=166: colour 1 is remapped, colour 0 is not.
    drive_cfg(1'b1, 1, 100, 166);
    tick();
    drive_cfg(1'b0, 0, 0, 0);
    drive_pix(100, 1, 1'b1, 1'b0);
    tick();
    drive_pix(100, 0, 1'b1, 1'b0);
    tick();
    chk("ch1_prog", 32'(bus.pixel_out), 166);
    drive_pix(0, 0, 1'b0, 1'b0);
    tick();
    chk("ch0_ident", 32'(bus.pixel_out), 100);

    // Write ch0[50]=121 in the cycle pixel 50 is at stage 1: old value, then new.
    drive_pix(50, 0, 1'b1, 1'b0);
    tick();
    drive_cfg(1'b1, 0, 50, 121);
    tick();
    chk("wr_same_cycle_old", 32'(bus.pixel_out), 50);
    drive_cfg(1'b0, 0, 0, 0);
    drive_pix(0, 0, 1'b0, 1'b0);
    tick();
    chk("wr_next_new", 32'(bus.pixel_out), 121);

    // Bypass with a programmed table, last_pic pulse, then out-of-range colour.
    drive_cfg(1'b1, 2, 7, 99);
    tick();
    drive_cfg(1'b0, 0, 0, 0);
    bus.bypass_en = 1'b1;
    drive_pix(7, 2, 1'b1, 1'b1);
    tick();
    drive_pix(9, 2, 1'b1, 1'b0);
    tick();
    chk("bypass_pix", 32'(bus.pixel_out), 7);
    chk("bypass_last", 32'(bus.last_pic_out), 1);
    tick();
    chk("last_pulse_end", 32'(bus.last_pic_out), 0);
    bus.bypass_en = 1'b0;
    drive_pix(7, 2, 1'b1, 1'b0);
    tick();
    drive_pix(200, 3, 1'b1, 1'b0);
    tick();
    chk("ch2_prog", 32'(bus.pixel_out), 99);
    drive_pix(0, 0, 1'b0, 1'b0);
    tick();
    chk("col3_pass", 32'(bus.pixel_out), 200);
    chk("col3_tag", 32'(bus.color_out), 3);

    // Randomised traffic on a narrow code range so writes and lookups collide.
    for (int i = 0; i < 500; i++) begin
      drive_pix((i % 4 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0));
      bus.bypass_en = ($urandom_range(0, 7) == 0);
      drive_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
`ifdef GAMMA_RDBACK_EN
      bus.cfg_re = 1'($urandom_range(0, 1));
`endif
      tick();
    end
    bus.bypass_en = 1'b0;
    drive_cfg(1'b0, 0, 0, 0);
    drive_pix(0, 0, 1'b0, 1'b0);
`ifdef GAMMA_RDBACK_EN
    bus.cfg_re = 1'b0;
    tick();

    // Readback: write ch2[255]=200, read it; read of a missing table; read+write same entry.
    drive_cfg(1'b1, 2, 255, 200);
    tick();
    drive_cfg(1'b0, 2, 255, 0);
    bus.cfg_re = 1'b1;
    tick();
    chk("rb_valid", 32'(bus.cfg_rvalid), 1);
    chk("rb_data", 32'(bus.cfg_rdata), 200);
    drive_cfg(1'b0, 3, 255, 0);
    tick();
    chk("rb_bad_ch", 32'(bus.cfg_rdata), 0);
    drive_cfg(1'b1, 2, 255, 17);
    tick();
    chk("rb_same_cycle_old", 32'(bus.cfg_rdata), 200);
    drive_cfg(1'b0, 2, 255, 0);
    tick();
    chk("rb_after_write", 32'(bus.cfg_rdata), 17);
    bus.cfg_re = 1'b0;
    tick();
    chk("rb_idle", 32'(bus.cfg_rvalid), 0);
`endif

    // Reset mid-RUN after programming: INIT reruns and the entry is identity again.
    drive_cfg(1'b1, 1, 100, 166);
    tick();
    drive_cfg(1'b0, 0, 0, 0);
    drive_pix(100, 1, 1'b1, 1'b0);
    tick();
    tick();
    chk("pre_reset_prog", 32'(bus.pixel_out), 166);
    do_reset(2);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.init_busy && n < 2000);
    chk("init_len_rerun", n, NENT);
    tick();
    tick();
    chk("post_reset_ident", 32'(bus.pixel_out), 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
